regfile_3r2w_param: RTL and testbench

REGFILE_3R2W_PARAM -- requirements
Module: regfile_3r2w_param

---
 rtl/regfile_3r2w_param.sv | 129 ++++++++++++
 tb/tb_regfile_3r2w_param.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_3r2w_param.sv
// rtl/regfile_3r2w_param.sv - parameterised register file, 3 read ports, 2 write ports
//
// Purpose: DEPTH = 2^AW entries of WIDTH bits. Each read port registers its
// address on rdx_en and presents the addressed entry combinationally
// (one-cycle latency). Port B wins a same-address double write, and
// wr_conflict flags that for one cycle. Entry 0 can be hardwired to zero.
// Same-cycle writes can be forwarded to the read outputs.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rd{a,b,c}_en/_addr        capture read address on rising edge
//   rd{a,b,c}_do              read data for the held address
//   wr{a,b}_en/_addr/_data    write ports (B has priority)
//   wr_conflict               registered same-address double-write flag
module regfile_3r2w_param #(
    parameter int WIDTH   = 32,
    parameter int AW      = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rda_en,
    input  logic [AW-1:0]    rda_addr,
    output logic [WIDTH-1:0] rda_do,
    input  logic             rdb_en,
    input  logic [AW-1:0]    rdb_addr,
    output logic [WIDTH-1:0] rdb_do,
    input  logic             rdc_en,
    input  logic [AW-1:0]    rdc_addr,
    output logic [WIDTH-1:0] rdc_do,
    input  logic             wra_en,
    input  logic [AW-1:0]    wra_addr,
    input  logic [WIDTH-1:0] wra_data,
    input  logic             wrb_en,
    input  logic [AW-1:0]    wrb_addr,
    input  logic [WIDTH-1:0] wrb_data,
    output logic             wr_conflict
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    ex_rda_addr_q, ex_rda_addr_d;
    logic [AW-1:0]    ex_rdb_addr_q, ex_rdb_addr_d;
    logic [AW-1:0]    ex_rdc_addr_q, ex_rdc_addr_d;
    logic             wr_conflict_q, wr_conflict_d;

    // Address 0 is treated as a non-register when hardwired: no writes,
    // no bypass, no conflict.
    logic wra_live, wrb_live;

    always_comb begin
        wra_live = wra_en && !((ZERO_R0 != 0) && (wra_addr == '0));
        wrb_live = wrb_en && !((ZERO_R0 != 0) && (wrb_addr == '0));
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            // Port B is tested first so it overrides port A on a collision.
            if (wrb_live && (wrb_addr == i[AW-1:0])) begin
                mem_d[i] = wrb_data;
            end else if (wra_live && (wra_addr == i[AW-1:0])) begin
                mem_d[i] = wra_data;
            end
        end
        ex_rda_addr_d = rda_en ? rda_addr : ex_rda_addr_q;
        ex_rdb_addr_d = rdb_en ? rdb_addr : ex_rdb_addr_q;
        ex_rdc_addr_d = rdc_en ? rdc_addr : ex_rdc_addr_q;
        wr_conflict_d = wra_live && wrb_live && (wra_addr == wrb_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ex_rda_addr_q <= '0;
            ex_rdb_addr_q <= '0;
            ex_rdc_addr_q <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            ex_rda_addr_q <= ex_rda_addr_d;
            ex_rdb_addr_q <= ex_rdb_addr_d;
            ex_rdc_addr_q <= ex_rdc_addr_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Read mux: zero entry, then forwarded write data (B over A), then array.
    function automatic logic [WIDTH-1:0] rd_sel(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] entry,
        input logic             a_live,
        input logic [AW-1:0]    a_addr,
        input logic [WIDTH-1:0] a_data,
        input logic             b_live,
        input logic [AW-1:0]    b_addr,
        input logic [WIDTH-1:0] b_data
    );
        logic [WIDTH-1:0] r;
        r = entry;
        if ((ZERO_R0 != 0) && (addr == '0)) begin
            r = '0;
        end else if ((BYPASS != 0) && b_live && (b_addr == addr)) begin
            r = b_data;
        end else if ((BYPASS != 0) && a_live && (a_addr == addr)) begin
            r = a_data;
        end
        return r;
    endfunction

    always_comb begin
        rda_do = rd_sel(ex_rda_addr_q, mem_q[ex_rda_addr_q], wra_live, wra_addr,
                        wra_data, wrb_live, wrb_addr, wrb_data);
        rdb_do = rd_sel(ex_rdb_addr_q, mem_q[ex_rdb_addr_q], wra_live, wra_addr,
                        wra_data, wrb_live, wrb_addr, wrb_data);
        rdc_do = rd_sel(ex_rdc_addr_q, mem_q[ex_rdc_addr_q], wra_live, wra_addr,
                        wra_data, wrb_live, wrb_addr, wrb_data);
    end

    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_3r2w_param.sv
// tb/tb_regfile_3r2w_param.sv - self-checking bench for regfile_3r2w_param
module tb_regfile_3r2w_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shared stimulus for the two 32x32 instances.
    logic        rst;
    logic        rda_en, rdb_en, rdc_en, wra_en, wrb_en;
    logic [4:0]  rda_addr, rdb_addr, rdc_addr, wra_addr, wrb_addr;
    logic [31:0] wra_data, wrb_data;
    logic [31:0] d0_rda, d0_rdb, d0_rdc, d1_rda, d1_rdb, d1_rdc;
    logic        d0_cf, d1_cf;

    // Stimulus for the 64-bit, 16-entry instance.
    logic        r2_rst;
    logic        r2_rda_en, r2_rdb_en, r2_rdc_en, r2_wra_en, r2_wrb_en;
    logic [3:0]  r2_rda_addr, r2_rdb_addr, r2_rdc_addr, r2_wra_addr, r2_wrb_addr;
    logic [63:0] r2_wra_data, r2_wrb_data;
    logic [63:0] d2_rda, d2_rdb, d2_rdc;
    logic        d2_cf;

    regfile_3r2w_param #(.WIDTH(32), .AW(5), .ZERO_R0(1), .BYPASS(1)) dut0 (
        .clk(clk), .rst(rst),
        .rda_en(rda_en), .rda_addr(rda_addr), .rda_do(d0_rda),
        .rdb_en(rdb_en), .rdb_addr(rdb_addr), .rdb_do(d0_rdb),
        .rdc_en(rdc_en), .rdc_addr(rdc_addr), .rdc_do(d0_rdc),
        .wra_en(wra_en), .wra_addr(wra_addr), .wra_data(wra_data),
        .wrb_en(wrb_en), .wrb_addr(wrb_addr), .wrb_data(wrb_data),
        .wr_conflict(d0_cf)
    );

    regfile_3r2w_param #(.WIDTH(32), .AW(5), .ZERO_R0(0), .BYPASS(0)) dut1 (
        .clk(clk), .rst(rst),
        .rda_en(rda_en), .rda_addr(rda_addr), .rda_do(d1_rda),
        .rdb_en(rdb_en), .rdb_addr(rdb_addr), .rdb_do(d1_rdb),
        .rdc_en(rdc_en), .rdc_addr(rdc_addr), .rdc_do(d1_rdc),
        .wra_en(wra_en), .wra_addr(wra_addr), .wra_data(wra_data),
        .wrb_en(wrb_en), .wrb_addr(wrb_addr), .wrb_data(wrb_data),
        .wr_conflict(d1_cf)
    );

    regfile_3r2w_param #(.WIDTH(64), .AW(4), .ZERO_R0(1), .BYPASS(1)) dut2 (
        .clk(clk), .rst(r2_rst),
        .rda_en(r2_rda_en), .rda_addr(r2_rda_addr), .rda_do(d2_rda),
        .rdb_en(r2_rdb_en), .rdb_addr(r2_rdb_addr), .rdb_do(d2_rdb),
        .rdc_en(r2_rdc_en), .rdc_addr(r2_rdc_addr), .rdc_do(d2_rdc),
        .wra_en(r2_wra_en), .wra_addr(r2_wra_addr), .wra_data(r2_wra_data),
        .wrb_en(r2_wrb_en), .wrb_addr(r2_wrb_addr), .wrb_data(r2_wrb_data),
        .wr_conflict(d2_cf)
    );

    // Reference state: what each register file should hold.
    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    logic [4:0]  ea, eb, ec;
    logic        c0, c1;
    logic [63:0] m2 [16];
    logic [3:0]  ea2, eb2, ec2;
    logic        c2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hardwired zero + forwarding view.
    function automatic logic [31:0] exp0(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wrb_en && wrb_addr == a) return wrb_data;
        if (wra_en && wra_addr == a) return wra_data;
        return m0[a];
    endfunction

    // Plain array view.
    function automatic logic [31:0] exp1(input logic [4:0] a);
        return m1[a];
    endfunction

    function automatic logic [63:0] exp2(input logic [3:0] a);
        if (a == 4'd0) return 64'h0;
        if (r2_wrb_en && r2_wrb_addr == a) return r2_wrb_data;
        if (r2_wra_en && r2_wra_addr == a) return r2_wra_data;
        return m2[a];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".d0a"}, 64'(d0_rda), 64'(exp0(ea)));
        chk({tag, ".d0b"}, 64'(d0_rdb), 64'(exp0(eb)));
        chk({tag, ".d0c"}, 64'(d0_rdc), 64'(exp0(ec)));
        chk({tag, ".d0cf"}, 64'(d0_cf), 64'(c0));
        chk({tag, ".d1a"}, 64'(d1_rda), 64'(exp1(ea)));
        chk({tag, ".d1b"}, 64'(d1_rdb), 64'(exp1(eb)));
        chk({tag, ".d1c"}, 64'(d1_rdc), 64'(exp1(ec)));
        chk({tag, ".d1cf"}, 64'(d1_cf), 64'(c1));
    endtask

    // Apply the current inputs to the reference, then advance one edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m0[i] = '0;
                m1[i] = '0;
            end
            ea = '0; eb = '0; ec = '0; c0 = 1'b0; c1 = 1'b0;
        end else begin
            if (rda_en) ea = rda_addr;
            if (rdb_en) eb = rdb_addr;
            if (rdc_en) ec = rdc_addr;
            if (wra_en && wra_addr != 0) m0[wra_addr] = wra_data;
            if (wrb_en && wrb_addr != 0) m0[wrb_addr] = wrb_data;
            if (wra_en) m1[wra_addr] = wra_data;
            if (wrb_en) m1[wrb_addr] = wrb_data;
            c0 = wra_en && wrb_en && (wra_addr == wrb_addr) && (wra_addr != 0);
            c1 = wra_en && wrb_en && (wra_addr == wrb_addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick2();
        if (r2_rst) begin
            for (int i = 0; i < 16; i++) m2[i] = '0;
            ea2 = '0; eb2 = '0; ec2 = '0; c2 = 1'b0;
        end else begin
            if (r2_rda_en) ea2 = r2_rda_addr;
            if (r2_rdb_en) eb2 = r2_rdb_addr;
            if (r2_rdc_en) ec2 = r2_rdc_addr;
            if (r2_wra_en && r2_wra_addr != 0) m2[r2_wra_addr] = r2_wra_data;
            if (r2_wrb_en && r2_wrb_addr != 0) m2[r2_wrb_addr] = r2_wrb_data;
            c2 = r2_wra_en && r2_wrb_en && (r2_wra_addr == r2_wrb_addr) && (r2_wra_addr != 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0;
        rda_en = 0; rdb_en = 0; rdc_en = 0; wra_en = 0; wrb_en = 0;
        rda_addr = 0; rdb_addr = 0; rdc_addr = 0; wra_addr = 0; wrb_addr = 0;
        wra_data = 0; wrb_data = 0;
    endtask

    initial begin
        idle();
        r2_rst = 1;
        r2_rda_en = 0; r2_rdb_en = 0; r2_rdc_en = 0; r2_wra_en = 0; r2_wrb_en = 0;
        r2_rda_addr = 0; r2_rdb_addr = 0; r2_rdc_addr = 0; r2_wra_addr = 0; r2_wrb_addr = 0;
        r2_wra_data = 0; r2_wrb_data = 0;
        for (int i = 0; i < 32; i++) begin m0[i] = 'x; m1[i] = 'x; end
        @(posedge clk);
        #1;

        // Reset state.
        rst = 1;
        tick();
        idle();
        #1;
        chk("rst.d0a", 64'(d0_rda), 64'h0);
        chk("rst.d1a", 64'(d1_rda), 64'h0);
        chk("rst.cf", 64'({d0_cf, d1_cf}), 64'h0);
        check_all("rst");

        // Single write then triple read of addr 5.
        wra_en = 1; wra_addr = 5; wra_data = 32'hDEADBEEF;
        tick();
        idle();
        rda_en = 1; rdb_en = 1; rdc_en = 1; rda_addr = 5; rdb_addr = 5; rdc_addr = 5;
        tick();
        idle();
        #1;
        chk("w5.d0a", 64'(d0_rda), 64'hDEADBEEF);
        chk("w5.d0c", 64'(d0_rdc), 64'hDEADBEEF);
        chk("w5.d1b", 64'(d1_rdb), 64'hDEADBEEF);
        check_all("w5");

        // Same-address double write: B wins, conflict for one cycle.
        wra_en = 1; wra_addr = 7; wra_data = 32'h11111111;
        wrb_en = 1; wrb_addr = 7; wrb_data = 32'h22222222;
        tick();
        idle();
        rda_en = 1; rda_addr = 7;
        #1;
        chk("cf.on0", 64'(d0_cf), 64'h1);
        chk("cf.on1", 64'(d1_cf), 64'h1);
        check_all("cf1");
        tick();
        idle();
        #1;
        chk("cf.data", 64'(d0_rda), 64'h22222222);
        chk("cf.off", 64'(d0_cf), 64'h0);
        check_all("cf2");

        // Bypass: hold addr 9, write it, observe same-cycle forwarding.
        rda_en = 1; rda_addr = 9;
        tick();
        idle();
        wra_en = 1; wra_addr = 9; wra_data = 32'hA5A5A5A5;
        #1;
        chk("byp.on", 64'(d0_rda), 64'hA5A5A5A5);
        chk("byp.off", 64'(d1_rda), 64'h0);
        check_all("byp1");
        tick();
        idle();
        #1;
        chk("byp.after", 64'(d1_rda), 64'hA5A5A5A5);
        check_all("byp2");

        // Writes to address 0 on both ports.
        wra_en = 1; wra_addr = 0; wra_data = 32'hFFFFFFFF;
        wrb_en = 1; wrb_addr = 0; wrb_data = 32'hFFFFFFFF;
        rda_en = 1; rda_addr = 0;
        tick();
        idle();
        #1;
        chk("z0.rd", 64'(d0_rda), 64'h0);
        chk("z0.cf", 64'(d0_cf), 64'h0);
        chk("z1.rd", 64'(d1_rda), 64'hFFFFFFFF);
        chk("z1.cf", 64'(d1_cf), 64'h1);
        check_all("z");

        // Fill all entries, then reset with a concurrent write.
        for (int i = 0; i < 32; i++) begin
            wra_en = 1; wra_addr = 5'(i); wra_data = 32'(i);
            tick();
        end
        idle();
        rda_en = 1; rda_addr = 31;
        tick();
        idle();
        #1;
        chk("fill.31", 64'(d0_rda), 64'd31);
        rst = 1; wra_en = 1; wra_addr = 3; wra_data = 32'd3;
        rdb_en = 1; rdb_addr = 3;
        tick();
        idle();
        #1;
        chk("rst2.d0a", 64'(d0_rda), 64'h0);
        chk("rst2.cf", 64'({d0_cf, d1_cf}), 64'h0);
        for (int i = 0; i < 32; i++) begin
            rda_en = 1; rdb_en = 1; rdc_en = 1;
            rda_addr = 5'(i); rdb_addr = 5'(i); rdc_addr = 5'(i);
            tick();
            idle();
            #1;
            chk("rst2.ent", 64'({d0_rda, d1_rda}), 64'h0);
            chk("rst2.entbc", 64'({d1_rdb, d1_rdc}), 64'h0);
        end

        // Random traffic on both 32-bit instances.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            rda_en = 1'($urandom); rdb_en = 1'($urandom); rdc_en = 1'($urandom);
            wra_en = 1'($urandom); wrb_en = 1'($urandom);
            rda_addr = 5'($urandom_range(0, 7)); rdb_addr = 5'($urandom_range(0, 7));
            rdc_addr = 5'($urandom_range(0, 7));
            wra_addr = 5'($urandom_range(0, 7)); wrb_addr = 5'($urandom_range(0, 7));
            wra_data = $urandom; wrb_data = $urandom;
            #1;
            check_all("rnd32");
            tick();
        end
        idle();

        // 64-bit, 16-entry sweep.
        tick2();
        r2_rst = 0;
        for (int n = 0; n < 10000; n++) begin
            r2_rst = ($urandom_range(0, 999) < 3);
            r2_rda_en = 1'($urandom); r2_rdb_en = 1'($urandom); r2_rdc_en = 1'($urandom);
            r2_wra_en = 1'($urandom); r2_wrb_en = 1'($urandom);
            r2_rda_addr = 4'($urandom); r2_rdb_addr = 4'($urandom); r2_rdc_addr = 4'($urandom);
            r2_wra_addr = 4'($urandom); r2_wrb_addr = 4'($urandom);
            r2_wra_data = {$urandom, $urandom}; r2_wrb_data = {$urandom, $urandom};
            #1;
            chk("rnd64.a", d2_rda, exp2(ea2));
            chk("rnd64.b", d2_rdb, exp2(eb2));
            chk("rnd64.c", d2_rdc, exp2(ec2));
            chk("rnd64.cf", 64'(d2_cf), 64'(c2));
            tick2();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
